// File: rtl/fetch_stage.sv
// MIPS IF stage: PC register, imem address drive, IF/ID register; FETCH_PERF_CNT_EN adds perf counters.
// Latency: word at pc reaches ifid_inst one clock later; imem is read combinationally.
// Backpressure: stall holds pc and IF/ID (overrides redirect); redirect squashes IF/ID to a bubble.
module fetch_stage #(
    parameter int              PC_W     = 32,
    parameter int              INST_W   = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [PC_W-1:0]   redirect_target,
    input  logic [INST_W-1:0] imem_inst,
    output logic [PC_W-1:0]   imem_addr,
    output logic [PC_W-1:0]   pc,
    output logic [INST_W-1:0] ifid_inst,
    output logic [PC_W-1:0]   ifid_pc_plus4,
    output logic              ifid_valid,
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_stalls,
    output logic [31:0]       perf_flushes
);

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [PC_W-1:0]   pc_plus4;
        logic              vld;
    } ifid_t;

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;
    logic [PC_W-1:0] pc_plus4;
    ifid_t           ifid_q;
    ifid_t           ifid_d;
    logic            advance;
    logic            flush;

    assign pc_plus4 = pc_q + PC_W'(4);
    assign advance  = !stall && !redirect_valid;
    assign flush    = !stall && redirect_valid;

    always_comb begin
        pc_d   = pc_q;
        ifid_d = ifid_q;
        if (flush) begin
            // Word fetched this cycle is wrong-path: replace it with a bubble.
            pc_d   = {redirect_target[PC_W-1:2], 2'b00};
            ifid_d = '0;
        end else if (advance) begin
            pc_d            = pc_plus4;
            ifid_d.inst     = imem_inst;
            ifid_d.pc_plus4 = pc_plus4;
            ifid_d.vld      = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q   <= RESET_PC;
            ifid_q <= '0;
        end else begin
            pc_q   <= pc_d;
            ifid_q <= ifid_d;
        end
    end

    assign pc            = pc_q;
    assign imem_addr     = pc_q;
    assign ifid_inst     = ifid_q.inst;
    assign ifid_pc_plus4 = ifid_q.pc_plus4;
    assign ifid_valid    = ifid_q.vld;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetched_q;
    logic [31:0] fetched_d;
    logic [31:0] stalls_q;
    logic [31:0] stalls_d;
    logic [31:0] flushes_q;
    logic [31:0] flushes_d;

    always_comb begin
        fetched_d = fetched_q + {31'd0, advance};
        stalls_d  = stalls_q  + {31'd0, stall};
        flushes_d = flushes_q + {31'd0, flush};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetched_q <= '0;
            stalls_q  <= '0;
            flushes_q <= '0;
        end else begin
            fetched_q <= fetched_d;
            stalls_q  <= stalls_d;
            flushes_q <= flushes_d;
        end
    end

    assign perf_fetched = fetched_q;
    assign perf_stalls  = stalls_q;
    assign perf_flushes = flushes_q;
`else
    assign perf_fetched = '0;
    assign perf_stalls  = '0;
    assign perf_flushes = '0;
`endif

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage of the 5-stage MIPS pipeline: owns the program counter, drives the byte address into the instruction memory, and captures the returned 32-bit word into the IF/ID pipeline register.
- Handles sequential PC+4 advance, taken-branch/jump redirect from ID, and load-use stall from the hazard unit.
- Sits between the hazard/branch logic in ID and the combinational instruction memory.

Parameters:
PC_W, 32, width of PC and instruction-memory address
INST_W, 32, instruction width (4 bytes, big-endian byte order handled by memory)
RESET_PC, 32'h0000_0000, PC value loaded on reset

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
stall  input  1  hazard unit: hold PC and IF/ID this cycle
redirect_valid  input  1  ID stage: branch taken or jump, load redirect_target
redirect_target  input  PC_W  ID stage: new PC (byte address)
imem_inst  input  INST_W  instruction word returned by instruction memory for imem_addr (same cycle)
imem_addr  output  PC_W  byte address to instruction memory (= pc)
pc  output  PC_W  current fetch PC
ifid_inst  output  INST_W  IF/ID registered instruction
ifid_pc_plus4  output  PC_W  IF/ID registered PC+4 of that instruction
ifid_valid  output  1  IF/ID holds a real instruction (0 = bubble)
perf_fetched  output  32  count of instructions latched into IF/ID (optional feature)
perf_stalls  output  32  count of stall cycles (optional feature)
perf_flushes  output  32  count of redirect flushes (optional feature)

Behaviour:
- Reset (async, immediate, also mid-operation): pc=RESET_PC, ifid_inst=0 (nop), ifid_pc_plus4=0, ifid_valid=0, perf counters=0.
- imem_addr = pc, combinational; memory read is zero-latency, so imem_inst is valid in the same cycle.
- Per rising edge, priority stall > redirect > normal:
  - stall=1: pc, ifid_inst, ifid_pc_plus4, ifid_valid all hold; redirect_valid ignored that cycle (branch in ID is itself stalled and re-presents next cycle).
  - stall=0, redirect_valid=1: pc <= {redirect_target[PC_W-1:2],2'b00}; ifid_inst <= 0; ifid_valid <= 0; ifid_pc_plus4 <= 0 (squash the wrong-path word fetched this cycle).
  - stall=0, redirect_valid=0: ifid_inst <= imem_inst; ifid_pc_plus4 <= pc+4; ifid_valid <= 1; pc <= pc+4.
- Arithmetic: pc+4 is PC_W bits modulo 2^PC_W; 32'hFFFF_FFFC advances to 32'h0000_0000 with no flag.
- Out-of-range addresses: memory returns all-zero word (nop); this block latches it as a normal valid instruction.
- Redirect target low two bits are always forced to 0; pc is always word-aligned.
- Latency: instruction at pc appears on ifid_inst one clock after pc presents it, absent stall/redirect.

Optional Feature:
Macro FETCH_PERF_CNT_EN.
- Defined: three 32-bit wrapping counters, updated on the same edge as the pipeline:
  - perf_fetched +1 on every normal advance;
  - perf_stalls +1 on every cycle with stall=1;
  - perf_flushes +1 on every cycle with stall=0 and redirect_valid=1.
- Not defined: counters not instantiated; the three perf outputs are tied to 0. Pipeline behaviour is identical either way.

Test Plan:
- Reset then 3 free-running clocks with memory words A,B,C at 0,4,8 -> pc=0,4,8,12; ifid_inst=A,B,C; ifid_pc_plus4=4,8,12; ifid_valid=1 from first edge.
- At pc=8 assert stall for 2 cycles -> pc stays 8, ifid_inst/ifid_pc_plus4 hold (B,8); release -> ifid_inst=C, pc=12; perf_stalls=2 with FETCH_PERF_CNT_EN.
- At pc=12 redirect_valid=1, target=32'h0000_0043 -> next pc=32'h0000_0040, ifid_valid=0, ifid_inst=0; following edge latches word at 0x40 with ifid_pc_plus4=0x44; perf_flushes=1.
- stall=1 and redirect_valid=1 together at pc=16 -> pc stays 16, IF/ID unchanged, perf_flushes unchanged; next cycle redirect alone takes effect.
- Force pc to 32'hFFFF_FFFC via redirect, clock once -> pc=0, ifid_pc_plus4=0, ifid_inst=0 (out-of-range word), ifid_valid=1.
- Assert rst asynchronously between edges mid-run -> pc=0, ifid_valid=0, ifid_inst=0, perf counters=0 immediately, before the next clock edge.
